// File: rtl/reg_bank_dbg.sv
// Architectural register file with two bypassed combinational read ports and a
// byte-serial debug dump engine (valid/ready) that streams every register LSB first.
module reg_bank_dbg #(
   parameter int NB_REG  = 32,
   parameter int NB_ADDR = 5,
   parameter int N_REGS  = 32
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_reg_write,
   input  logic [NB_ADDR-1:0] i_write_addr,
   input  logic [NB_REG-1:0]  i_write_data,
   input  logic [NB_ADDR-1:0] i_rs_addr,
   input  logic [NB_ADDR-1:0] i_rt_addr,
   output logic [NB_REG-1:0]  o_rs_data,
   output logic [NB_REG-1:0]  o_rt_data,
   input  logic               i_dbg_start,
   input  logic               i_dbg_ready,
   output logic               o_dbg_valid,
   output logic [7:0]         o_dbg_byte,
   output logic               o_dbg_busy,
   output logic               o_dbg_done
);

   localparam int NB_BYTES = NB_REG / 8;
   localparam int BSEL_W   = $clog2(NB_BYTES);
   localparam int IDX_W    = NB_ADDR + BSEL_W;
   localparam logic [IDX_W-1:0] IDX_LAST = '1;
   localparam logic [IDX_W+2:0] OFF_MASK = (IDX_W+3)'(NB_REG - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               done_q, done_d;
   logic [NB_REG-1:0]  regs_q [N_REGS];
   logic [NB_REG-1:0]  regs_d [N_REGS];

   logic [NB_ADDR-1:0] dump_reg;
   logic [NB_REG-1:0]  dump_word;
   logic [NB_REG-1:0]  dump_shifted;

   always_comb begin
      regs_d = regs_q;
      if (i_reg_write && i_write_addr != '0)
         regs_d[i_write_addr] = i_write_data;
   end

   // r0 is hardwired to zero and must win over the WB bypass
   assign o_rs_data = (i_rs_addr == '0) ? '0 :
                      (i_reg_write && i_rs_addr == i_write_addr) ? i_write_data :
                      regs_q[i_rs_addr];
   assign o_rt_data = (i_rt_addr == '0) ? '0 :
                      (i_reg_write && i_rt_addr == i_write_addr) ? i_write_data :
                      regs_q[i_rt_addr];

   // Dump reads committed state only; a write lands on the next byte presented
   assign dump_reg     = idx_q[IDX_W-1 -: NB_ADDR];
   assign dump_word    = regs_q[dump_reg];
   assign dump_shifted = dump_word >> ({idx_q, 3'b000} & OFF_MASK);
   assign o_dbg_byte   = dump_shifted[7:0];

   assign o_dbg_valid = (state_q == SEND);
   assign o_dbg_busy  = (state_q == SEND);
   assign o_dbg_done  = done_q;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_dbg_start) begin
               state_d = SEND;
               idx_d   = '0;
            end
         end
         SEND: begin
            if (i_dbg_ready) begin
               if (idx_q == IDX_LAST) begin
                  state_d = IDLE;
                  idx_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         done_q  <= 1'b0;
         for (int i = 0; i < N_REGS; i++)
            regs_q[i] <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         regs_q  <= regs_d;
      end
   end

endmodule

// File: tb/tb_reg_bank_dbg.sv
// Directed bench for reg_bank_dbg: read/bypass checks plus dump runs checked
// against a register model and a byte scoreboard.
module tb_reg_bank_dbg;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_reg_write = 1'b0;
   logic [4:0]  i_write_addr = '0;
   logic [31:0] i_write_data = '0;
   logic [4:0]  i_rs_addr = '0;
   logic [4:0]  i_rt_addr = '0;
   logic [31:0] o_rs_data, o_rt_data;
   logic        i_dbg_start = 1'b0;
   logic        i_dbg_ready = 1'b0;
   logic        o_dbg_valid;
   logic [7:0]  o_dbg_byte;
   logic        o_dbg_busy;
   logic        o_dbg_done;

   reg_bank_dbg #(.NB_REG(32), .NB_ADDR(5), .N_REGS(32)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_reg_write(i_reg_write), .i_write_addr(i_write_addr), .i_write_data(i_write_data),
      .i_rs_addr(i_rs_addr), .i_rt_addr(i_rt_addr),
      .o_rs_data(o_rs_data), .o_rt_data(o_rt_data),
      .i_dbg_start(i_dbg_start), .i_dbg_ready(i_dbg_ready),
      .o_dbg_valid(o_dbg_valid), .o_dbg_byte(o_dbg_byte),
      .o_dbg_busy(o_dbg_busy), .o_dbg_done(o_dbg_done)
   );

   always #5 i_clk = ~i_clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] mdl [32];
   logic [7:0]  sb_q [$];
   logic [7:0]  got [128];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] mbyte(input int i);
      logic [31:0] w;
      w = mdl[i / 4];
      return w[8*(i % 4) +: 8];
   endfunction

   // Runs one dump. rdy_mod: ready high 1-of-rdy_mod cycles. wr_idx: at that
   // byte, write r5=FFFFFFFF and re-pulse start. rst_idx: reset at that byte.
   task automatic dump(input int rdy_mod, input int wr_idx, input int rst_idx);
      int   k = 0;
      int   cyc = 0;
      bit   aborted = 0;
      bit   wrote = 0;
      logic [7:0] exp_b;
      @(negedge i_clk);
      i_dbg_start = 1'b1;
      @(negedge i_clk);
      i_dbg_start = 1'b0;
      while (k < 128 && cyc < 2000) begin
         i_dbg_ready = (rdy_mod <= 1) ? 1'b1 : ((cyc % rdy_mod) == 0);
         i_reg_write = 1'b0;
         i_dbg_start = 1'b0;
         if (k == wr_idx && !wrote) begin
            i_reg_write  = 1'b1;
            i_write_addr = 5'd5;
            i_write_data = 32'hFFFF_FFFF;
            i_dbg_start  = 1'b1;
            wrote = 1;
         end
         if (k == rst_idx) i_rst_n = 1'b0;
         if (i_dbg_ready && i_rst_n) sb_q.push_back(mbyte(k));
         #1;
         chk("dbg_valid", {31'd0, o_dbg_valid}, 32'd1);
         chk("dbg_busy", {31'd0, o_dbg_busy}, 32'd1);
         if (i_dbg_ready && i_rst_n) begin
            exp_b = sb_q.pop_front();
            chk($sformatf("dbg_byte[%0d]", k), {24'd0, o_dbg_byte}, {24'd0, exp_b});
            got[k] = o_dbg_byte;
         end else begin
            chk($sformatf("dbg_hold[%0d]", k), {24'd0, o_dbg_byte}, {24'd0, mbyte(k)});
         end
         @(negedge i_clk);
         if (!i_rst_n) begin
            aborted = 1;
            for (int r = 0; r < 32; r++) mdl[r] = '0;
            i_rst_n = 1'b1;
            break;
         end
         if (i_reg_write && i_write_addr != 0) mdl[i_write_addr] = i_write_data;
         if (i_dbg_ready) k++;
         cyc++;
      end
      i_dbg_ready = 1'b0;
      i_reg_write = 1'b0;
      i_dbg_start = 1'b0;
      if (cyc >= 2000) chk("dump_timeout", 32'd0, 32'd1);
      #1;
      chk("post_valid", {31'd0, o_dbg_valid}, 32'd0);
      chk("post_busy", {31'd0, o_dbg_busy}, 32'd0);
      chk("done_pulse", {31'd0, o_dbg_done}, aborted ? 32'd0 : 32'd1);
      @(negedge i_clk);
      #1;
      chk("done_clear", {31'd0, o_dbg_done}, 32'd0);
      chk("idle_valid", {31'd0, o_dbg_valid}, 32'd0);
   endtask

   initial begin
      for (int r = 0; r < 32; r++) mdl[r] = '0;

      repeat (2) @(negedge i_clk);
      i_rs_addr = 5'd5;
      i_rt_addr = 5'd31;
      #1;
      chk("rst_valid", {31'd0, o_dbg_valid}, 32'd0);
      chk("rst_busy", {31'd0, o_dbg_busy}, 32'd0);
      chk("rst_done", {31'd0, o_dbg_done}, 32'd0);
      chk("rst_rs5", o_rs_data, 32'd0);
      chk("rst_rt31", o_rt_data, 32'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;

      // r0 write is dropped, no bypass
      @(negedge i_clk);
      i_reg_write = 1'b1; i_write_addr = 5'd0; i_write_data = 32'hDEAD_BEEF;
      i_rs_addr = 5'd0; i_rt_addr = 5'd0;
      #1;
      chk("r0_bypass_rs", o_rs_data, 32'd0);
      chk("r0_bypass_rt", o_rt_data, 32'd0);
      @(negedge i_clk);
      i_reg_write = 1'b0;
      #1;
      chk("r0_rs", o_rs_data, 32'd0);
      chk("r0_rt", o_rt_data, 32'd0);

      // Dual bypass then stored value
      @(negedge i_clk);
      i_reg_write = 1'b1; i_write_addr = 5'd7; i_write_data = 32'h1234_5678;
      i_rs_addr = 5'd7; i_rt_addr = 5'd7;
      #1;
      chk("r7_bypass_rs", o_rs_data, 32'h1234_5678);
      chk("r7_bypass_rt", o_rt_data, 32'h1234_5678);
      @(negedge i_clk);
      mdl[7] = 32'h1234_5678;
      i_reg_write = 1'b0;
      #1;
      chk("r7_rs", o_rs_data, mdl[7]);
      chk("r7_rt", o_rt_data, mdl[7]);

      // One port stored, other bypassed
      @(negedge i_clk);
      i_reg_write = 1'b1; i_write_addr = 5'd3; i_write_data = 32'hA5A5_A5A5;
      i_rs_addr = 5'd7; i_rt_addr = 5'd3;
      #1;
      chk("mix_rs_stored", o_rs_data, mdl[7]);
      chk("mix_rt_bypass", o_rt_data, 32'hA5A5_A5A5);
      @(negedge i_clk);
      mdl[3] = 32'hA5A5_A5A5;
      i_write_addr = 5'd4; i_write_data = 32'h0102_0304;
      i_rs_addr = 5'd3; i_rt_addr = 5'd1;
      #1;
      chk("r3_rs", o_rs_data, mdl[3]);
      chk("r1_rt", o_rt_data, 32'd0);
      @(negedge i_clk);
      mdl[4] = 32'h0102_0304;
      i_reg_write = 1'b0;

      dump(1, -1, -1);
      chk("byte12", {24'd0, got[12]}, 32'hA5);
      chk("byte15", {24'd0, got[15]}, 32'hA5);
      chk("byte16", {24'd0, got[16]}, 32'h04);
      chk("byte17", {24'd0, got[17]}, 32'h03);
      chk("byte18", {24'd0, got[18]}, 32'h02);
      chk("byte19", {24'd0, got[19]}, 32'h01);
      chk("byte28", {24'd0, got[28]}, 32'h78);

      dump(3, -1, -1);
      chk("stall_byte16", {24'd0, got[16]}, 32'h04);

      dump(1, 20, -1);
      chk("live_byte20_old", {24'd0, got[20]}, 32'h00);
      chk("live_byte21_new", {24'd0, got[21]}, 32'hFF);
      chk("live_byte23_new", {24'd0, got[23]}, 32'hFF);

      dump(1, -1, 60);
      for (int a = 0; a < 32; a++) begin
         @(negedge i_clk);
         i_rs_addr = 5'(a);
         i_rt_addr = 5'(31 - a);
         #1;
         chk($sformatf("post_rst_rs%0d", a), o_rs_data, 32'd0);
         chk($sformatf("post_rst_rt%0d", 31 - a), o_rt_data, 32'd0);
      end

      dump(1, -1, -1);
      chk("restart_byte0", {24'd0, got[0]}, 32'h00);
      chk("restart_byte20", {24'd0, got[20]}, 32'h00);
      chk("scoreboard_empty", sb_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
